d_pop_arbiter: RTL and testbench

D_POP_ARBITER -- requirements
Module: d_pop_arbiter

---
 rtl/d_pop_arbiter.sv | 139 +++++++++++++
 tb/tb_d_pop_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/d_pop_arbiter.sv
// d_pop_arbiter: merges two first-word-fall-through FIFOs into one registered
// output stream. Round-robin between the two sources, with one output holding
// register (EMPTY/FULL). The register loads a new word in the same cycle it
// delivers the old one. Also checks each word's route bit and counts
// delivered words per source, saturating at all-ones.
module d_pop_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_out_D0,
  input  logic [DATA_WIDTH-1:0] data_out_D1,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic                  out_ready,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out,
  output logic                  error_route,
  output logic [CNT_WIDTH-1:0]  count_D0,
  output logic [CNT_WIDTH-1:0]  count_D1
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    src_q;
  logic                    last_q;
  logic                    err_q;
  logic [CNT_WIDTH-1:0]    cnt0_q;
  logic [CNT_WIDTH-1:0]    cnt1_q;

  logic                    cand0_s;
  logic                    cand1_s;
  logic                    can_load_s;
  logic                    pop_en_s;
  logic                    pick_s;
  logic [DATA_WIDTH-1:0]   word_s;
  logic                    misroute_s;
  logic                    deliver_s;
  logic [CNT_WIDTH-1:0]    cnt0_d;
  logic [CNT_WIDTH-1:0]    cnt1_d;

  assign valid_out   = (state_q == ST_FULL);
  assign data_out    = data_q;
  assign src_out     = src_q;
  assign error_route = err_q;
  assign count_D0    = cnt0_q;
  assign count_D1    = cnt1_q;

  // Arbitration: choose a source, decide whether to pop, and run the route check.
  always_comb begin
    cand0_s    = ~empty_fifo_D0;
    cand1_s    = ~empty_fifo_D1;
    can_load_s = (state_q == ST_EMPTY) || (valid_out && out_ready);
    pop_en_s   = enable && can_load_s && !reset && (cand0_s || cand1_s);
    if (cand0_s && cand1_s) begin
      pick_s = ~last_q;          // alternate against the last served source
    end else if (cand1_s) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    word_s     = pick_s ? data_out_D1 : data_out_D0;
    misroute_s = (word_s[DATA_WIDTH-1] != pick_s);
    D0_pop     = pop_en_s && !pick_s;
    D1_pop     = pop_en_s && pick_s;
  end

  // Delivery detection and saturating next values for the per-source counters.
  always_comb begin
    deliver_s = valid_out && out_ready;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (deliver_s && !src_q) begin
      cnt0_d = (cnt0_q == CNT_MAX) ? cnt0_q : (cnt0_q + CNT_ONE);
    end else if (deliver_s && src_q) begin
      cnt1_d = (cnt1_q == CNT_MAX) ? cnt1_q : (cnt1_q + CNT_ONE);
    end else begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
    end
  end

  // Output register FSM plus the holding register, sticky error flag and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= {DATA_WIDTH{1'b0}};
      src_q   <= 1'b0;
      last_q  <= 1'b1;               // makes D0 win the first tie
      err_q   <= 1'b0;
      cnt0_q  <= {CNT_WIDTH{1'b0}};
      cnt1_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      case (state_q)
        ST_EMPTY: begin
          if (pop_en_s) begin
            state_q <= ST_FULL;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop_en_s) begin
            state_q <= ST_FULL;      // deliver and reload in the same cycle
          end else if (out_ready) begin
            state_q <= ST_EMPTY;
          end else begin
            state_q <= ST_FULL;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (pop_en_s) begin
        data_q <= word_s;            // misrouted words are forwarded unchanged
        src_q  <= pick_s;
        last_q <= pick_s;
        if (misroute_s) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_d_pop_arbiter.sv
// Testbench for d_pop_arbiter. The bench plays both FIFOs with queues, and a
// transaction-level reference model predicts pops, the held word and the counters.
module tb_d_pop_arbiter;

  localparam int DW   = 6;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] data_out_D0, data_out_D1;
  logic          empty_fifo_D0, empty_fifo_D1;
  logic          out_ready;
  logic          D0_pop, D1_pop;
  logic [DW-1:0] data_out;
  logic          valid_out, src_out, error_route;
  logic [CW-1:0] count_D0, count_D1;

  d_pop_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .out_ready(out_ready), .D0_pop(D0_pop), .D1_pop(D1_pop),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .error_route(error_route), .count_D0(count_D0), .count_D1(count_D1)
  );

  always #5 clk = ~clk;

  // bench-side FIFOs and reference model
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            m_valid, m_src, m_last, m_err;
  logic [DW-1:0] m_data;
  int            m_c0, m_c1;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1; m_err = 1'b0;
    m_data = '0; m_c0 = 0; m_c1 = 0;
  endtask

  task automatic drive_fifos();
    data_out_D0   = (q0.size() > 0) ? q0[0] : DW'($urandom);
    data_out_D1   = (q1.size() > 0) ? q1[0] : DW'($urandom);
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
    if (m_valid) begin
      chk({tag, ".data"}, {26'd0, data_out}, {26'd0, m_data});
      chk({tag, ".src"},  {31'd0, src_out},  {31'd0, m_src});
    end
    chk({tag, ".err"}, {31'd0, error_route}, {31'd0, m_err});
    chk({tag, ".cnt0"}, {24'd0, count_D0}, m_c0);
    chk({tag, ".cnt1"}, {24'd0, count_D1}, m_c1);
  endtask

  // one clock cycle: predict pops, check them, then advance the model past the edge
  task automatic step(input bit en, input bit rdy, input string tag);
    bit c0, c1, can, pe, pk;
    logic [DW-1:0] w;
    enable = en; out_ready = rdy;
    drive_fifos();
    c0  = (q0.size() > 0);
    c1  = (q1.size() > 0);
    can = !m_valid || rdy;
    pe  = en && can && (c0 || c1);
    pk  = (c0 && c1) ? !m_last : c1;
    #1;
    chk({tag, ".D0_pop"}, {31'd0, D0_pop}, {31'd0, pe && !pk});
    chk({tag, ".D1_pop"}, {31'd0, D1_pop}, {31'd0, pe && pk});
    @(posedge clk);
    if (m_valid && rdy) begin
      if (m_src) m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
      else       m_c0 = (m_c0 < CMAX) ? m_c0 + 1 : CMAX;
    end
    if (pe) begin
      w = pk ? q1.pop_front() : q0.pop_front();
      if (w[DW-1] != pk) m_err = 1'b1;
      m_data = w; m_src = pk; m_last = pk; m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    chk_outputs(tag);
  endtask

  // assert reset between edges, check the asynchronous clear, release after one edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    drive_fifos();
    #1;
    chk({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, ".data"},  {26'd0, data_out},  32'd0);
    chk({tag, ".src"},   {31'd0, src_out},   32'd0);
    chk({tag, ".err"},   {31'd0, error_route}, 32'd0);
    chk({tag, ".cnt0"},  {24'd0, count_D0},  32'd0);
    chk({tag, ".cnt1"},  {24'd0, count_D1},  32'd0);
    chk({tag, ".D0_pop"}, {31'd0, D0_pop}, 32'd0);
    chk({tag, ".D1_pop"}, {31'd0, D1_pop}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, tag);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    data_out_D0 = '0; data_out_D1 = '0;
    empty_fifo_D0 = 1'b1; empty_fifo_D1 = 1'b1;
    model_reset();
    @(posedge clk); #1;
    // pops stay low under reset even with both FIFOs non-empty
    q0.push_back(6'd1); q0.push_back(6'd2);
    q1.push_back(6'd33); q1.push_back(6'd34);
    do_reset("rst0");

    // alternating sequence with full throughput
    step(1'b1, 1'b1, "rr1"); chk("rr1.seq", {26'd0, data_out}, 32'd1);
    step(1'b1, 1'b1, "rr2"); chk("rr2.seq", {26'd0, data_out}, 32'd33);
    step(1'b1, 1'b1, "rr3"); chk("rr3.seq", {26'd0, data_out}, 32'd2);
    step(1'b1, 1'b1, "rr4"); chk("rr4.seq", {26'd0, data_out}, 32'd34);
    step(1'b1, 1'b1, "rr5");
    chk("rr.cnt0", {24'd0, count_D0}, 32'd2);
    chk("rr.cnt1", {24'd0, count_D1}, 32'd2);

    // backpressure: one pop, word held for three cycles
    q0.push_back(6'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, "bp");
      chk("bp.hold", {26'd0, data_out}, 32'd3);
    end
    step(1'b1, 1'b1, "bp_rel");
    chk("bp.cnt0", {24'd0, count_D0}, 32'd3);

    // misroute from D1 sets the sticky flag
    q1.push_back(6'd4);
    step(1'b1, 1'b1, "mr1");
    chk("mr.err1", {31'd0, error_route}, 32'd1);
    step(1'b1, 1'b1, "mr2");
    step(1'b1, 1'b1, "mr3");
    chk("mr.err_sticky", {31'd0, error_route}, 32'd1);

    // enable low blocks popping; D0 goes first after reset
    do_reset("rst1");
    q0.push_back(6'd5); q1.push_back(6'h21);
    step(1'b0, 1'b1, "en0a");
    step(1'b0, 1'b1, "en0b");
    chk("en0.valid", {31'd0, valid_out}, 32'd0);
    step(1'b1, 1'b1, "en1");
    chk("en1.src", {31'd0, src_out}, 32'd0);
    drain("en_drain");

    // counter saturation
    for (int i = 0; i < 260; i++) begin
      q0.push_back(DW'($urandom_range(0, 31)));
      step(1'b1, 1'b1, "sat");
    end
    step(1'b1, 1'b1, "sat_last");
    chk("sat.cnt0", {24'd0, count_D0}, 32'd255);
    step(1'b1, 1'b1, "sat_hold");
    chk("sat.hold", {24'd0, count_D0}, 32'd255);

    // randomized traffic
    do_reset("rst2");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0)
        q0.push_back({($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 5'($urandom)});
      if ($urandom_range(0, 2) == 0)
        q1.push_back({($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1, 5'($urandom)});
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), "rnd");
    end

    // reset while a word is held: discarded, nothing counted
    q0.push_back(6'd7);
    step(1'b1, 1'b0, "mid");
    chk("mid.valid_before", {31'd0, valid_out}, 32'd1);
    do_reset("rst3");
    drain("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
